// File: rtl/uart_xcvr.sv
// uart_xcvr: runtime-divisor UART transceiver with 16x oversampled majority-vote RX, parity and error flags
module uart_xcvr #(
  parameter int DLEN = 8,
  parameter int DIVW = 16,
  parameter int RST_DIV = 651
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DIVW-1:0] i_div,
  input  logic            i_par_en,
  input  logic            i_par_odd,
  input  logic            i_two_stop,
  input  logic            i_rxs,
  output logic            o_tx,
  input  logic            i_wvalid,
  output logic            o_wready,
  input  logic [DLEN-1:0] i_wdata,
  output logic            o_rvalid,
  input  logic            i_rready,
  output logic [DLEN-1:0] o_rdata,
  output logic            o_frame_err,
  output logic            o_par_err,
  output logic            o_overrun
);
  localparam int BW = $clog2(DLEN);
  localparam logic [BW-1:0] LAST = BW'(DLEN - 1);
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP1, TX_STOP2} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  tx_state_t tx_st, tx_nx;
  rx_state_t rx_st, rx_nx;
  logic [DIVW-1:0] tx_div, tx_cnt, rx_div, rx_cnt;
  logic [3:0] tx_sub, rx_sub;
  logic [BW-1:0] tx_bit, rx_bit;
  logic [DLEN-1:0] tx_sh, rx_sh;
  logic [1:0] rx_smp;
  logic tx_pen, tx_pv, tx_two, tx_tick, tx_end, tx_go;
  logic rx_pen, rx_podd, rx_perr, rxs_q, rx_tick, rx_end, rx_dec, rx_maj, rx_go, rx_wr;
  assign tx_tick = tx_cnt == tx_div - DIVW'(1);
  assign tx_end = tx_tick && tx_sub == 4'd15;
  assign tx_go = tx_st == TX_IDLE && i_wvalid;
  assign o_wready = tx_st == TX_IDLE;
  assign o_tx = tx_st == TX_START ? 1'b0 : tx_st == TX_DATA ? tx_sh[0] : tx_st == TX_PAR ? tx_pv : 1'b1;
  always_comb begin
    tx_nx = tx_st;
    case (tx_st)
      TX_IDLE:  tx_nx = i_wvalid ? TX_START : TX_IDLE;
      TX_START: tx_nx = tx_end ? TX_DATA : TX_START;
      TX_DATA:  tx_nx = tx_end && tx_bit == LAST ? (tx_pen ? TX_PAR : TX_STOP1) : TX_DATA;
      TX_PAR:   tx_nx = tx_end ? TX_STOP1 : TX_PAR;
      TX_STOP1: tx_nx = tx_end ? (tx_two ? TX_STOP2 : TX_IDLE) : TX_STOP1;
      TX_STOP2: tx_nx = tx_end ? TX_IDLE : TX_STOP2;
      default:  tx_nx = TX_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st <= TX_IDLE;
      tx_div <= DIVW'(RST_DIV);
      tx_cnt <= '0;
      tx_sub <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      tx_pen <= 1'b0;
      tx_pv <= 1'b0;
      tx_two <= 1'b0;
    end else begin
      tx_st <= tx_nx;
      if (tx_go) begin
        tx_div <= i_div == '0 ? DIVW'(1) : i_div;
        tx_cnt <= '0;
        tx_sub <= '0;
        tx_bit <= '0;
        tx_sh <= i_wdata;
        tx_pen <= i_par_en;
        tx_pv <= ^i_wdata ^ i_par_odd;
        tx_two <= i_two_stop;
      end else begin
        tx_cnt <= tx_tick ? '0 : tx_cnt + DIVW'(1);
        if (tx_tick) tx_sub <= tx_sub + 4'd1;
        if (tx_end && tx_st == TX_DATA) begin
          tx_sh <= tx_sh >> 1;
          tx_bit <= tx_bit + BW'(1);
        end
      end
    end
  end
  // samples from ticks 7 and 8 are held; tick 9 votes with the live line
  assign rx_tick = rx_cnt == rx_div - DIVW'(1);
  assign rx_end = rx_tick && rx_sub == 4'd15;
  assign rx_dec = rx_tick && rx_sub == 4'd9;
  assign rx_maj = (rx_smp[1] & rx_smp[0]) | (rx_smp[1] & i_rxs) | (rx_smp[0] & i_rxs);
  assign rx_go = rx_st == RX_IDLE && rxs_q && !i_rxs;
  assign rx_wr = rx_st == RX_STOP && rx_dec;
  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      RX_IDLE:  rx_nx = rx_go ? RX_START : RX_IDLE;
      RX_START: rx_nx = rx_dec && rx_maj ? RX_IDLE : rx_end ? RX_DATA : RX_START;
      RX_DATA:  rx_nx = rx_end && rx_bit == LAST ? (rx_pen ? RX_PAR : RX_STOP) : RX_DATA;
      RX_PAR:   rx_nx = rx_end ? RX_STOP : RX_PAR;
      RX_STOP:  rx_nx = rx_dec ? RX_IDLE : RX_STOP;
      default:  rx_nx = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st <= RX_IDLE;
      rx_div <= DIVW'(RST_DIV);
      rx_cnt <= '0;
      rx_sub <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_smp <= '0;
      rx_pen <= 1'b0;
      rx_podd <= 1'b0;
      rx_perr <= 1'b0;
      rxs_q <= 1'b1;
    end else begin
      rx_st <= rx_nx;
      rxs_q <= i_rxs;
      if (rx_go) begin
        rx_div <= i_div == '0 ? DIVW'(1) : i_div;
        rx_cnt <= '0;
        rx_sub <= '0;
        rx_bit <= '0;
        rx_pen <= i_par_en;
        rx_podd <= i_par_odd;
        rx_perr <= 1'b0;
      end else begin
        rx_cnt <= rx_tick ? '0 : rx_cnt + DIVW'(1);
        if (rx_tick) rx_sub <= rx_sub + 4'd1;
        if (rx_tick && (rx_sub == 4'd7 || rx_sub == 4'd8)) rx_smp <= {rx_smp[0], i_rxs};
        if (rx_dec && rx_st == RX_DATA) rx_sh <= {rx_maj, rx_sh[DLEN-1:1]};
        if (rx_dec && rx_st == RX_PAR) rx_perr <= rx_maj != (^rx_sh ^ rx_podd);
        if (rx_end && rx_st == RX_DATA) rx_bit <= rx_bit + BW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rvalid <= 1'b0;
      o_rdata <= '0;
      o_frame_err <= 1'b0;
      o_par_err <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= rx_wr && o_rvalid && !i_rready;
      if (rx_wr && (!o_rvalid || i_rready)) begin
        o_rvalid <= 1'b1;
        o_rdata <= rx_sh;
        o_frame_err <= !rx_maj;
        o_par_err <= rx_perr;
      end else if (o_rvalid && i_rready) begin
        o_rvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: table-driven and randomized checks of uart_xcvr against a frame-level line model
module tb_uart_xcvr;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, par_en, par_odd, two_stop, rxs, tx, wvalid, wready, rvalid, rready;
  logic frame_err, par_err, overrun, loop, drv;
  logic [15:0] div;
  logic [7:0] wdata, rdata;
  assign rxs = loop ? tx : drv;
  uart_xcvr #(.DLEN(8), .DIVW(16), .RST_DIV(651)) dut (
    .clk(clk), .rst(rst), .i_div(div), .i_par_en(par_en), .i_par_odd(par_odd),
    .i_two_stop(two_stop), .i_rxs(rxs), .o_tx(tx), .i_wvalid(wvalid), .o_wready(wready),
    .i_wdata(wdata), .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata),
    .o_frame_err(frame_err), .o_par_err(par_err), .o_overrun(overrun)
  );
  int checks = 0;
  int failures = 0;
  int rd_idx = 0;
  int ovr_cnt = 0;
  typedef struct {logic [7:0] d; logic fe; logic pe;} rx_t;
  rx_t rxq[$];
  always @(negedge clk) begin
    if (!rst && rvalid && rready) rxq.push_back('{d: rdata, fe: frame_err, pe: par_err});
    if (!rst && overrun) ovr_cnt++;
  end
  initial begin
    #800000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic expect_rx(input string nm, input logic [7:0] d, input logic fe, input logic pe);
    if (rxq.size() <= rd_idx) begin
      checks++;
      failures++;
      $display("FAIL %s: no frame received, expected data %0h", nm, d);
    end else begin
      chk({nm, " data"}, 32'(rxq[rd_idx].d), 32'(d));
      chk({nm, " ferr"}, 32'(rxq[rd_idx].fe), 32'(fe));
      chk({nm, " perr"}, 32'(rxq[rd_idx].pe), 32'(pe));
      rd_idx++;
    end
  endtask
  // Send one frame and compare o_tx every cycle with the ideal line waveform
  task automatic send_tx(input string nm, input logic [7:0] d, input logic [15:0] dv, input logic pe,
                         input logic po, input logic ts, output int len_meas, output logic par_meas);
    logic [11:0] bits;
    int nb, bt, bad, g;
    nb = 10 + int'(pe) + int'(ts);
    bt = 16 * (dv == 0 ? 1 : int'(dv));
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (pe) bits[9] = ^d ^ po;
    div = dv; par_en = pe; par_odd = po; two_stop = ts; wdata = d; wvalid = 1'b1;
    g = 0;
    while (wready !== 1'b1 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0;
    bad = 0;
    len_meas = -1;
    par_meas = 1'bx;
    for (int t = 0; t <= nb * bt; t++) begin
      if (t > 0) @(negedge clk);
      if (t < nb * bt) begin
        if (tx !== bits[t/bt] || wready !== 1'b0) bad++;
        if (pe && t == 9 * bt + bt / 2) par_meas = tx;
      end else if (tx !== 1'b1) bad++;
      if (wready === 1'b1 && len_meas < 0) len_meas = t;
    end
    chk({nm, " wave"}, 32'(bad), 32'd0);
  endtask
  // Bit-bang one RX frame; optional parity flip, low stop bit and a one-cycle glitch on a middle sample
  task automatic drive_rx(input logic [7:0] d, input logic [15:0] dv, input logic pe, input logic po,
                          input logic flip, input logic stop_low, input int gb);
    logic [10:0] bits;
    int nb, dd, bt;
    dd = dv == 0 ? 1 : int'(dv);
    bt = 16 * dd;
    nb = 10 + int'(pe);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (pe) bits[9] = ^d ^ po ^ flip;
    bits[nb-1] = !stop_low;
    div = dv; par_en = pe; par_odd = po;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < bt; c++) begin
        drv = bits[b] ^ (b == gb && c == 9 * dd);
        @(negedge clk);
      end
    drv = 1'b1;
    repeat (2 * bt) @(negedge clk);
  endtask
  typedef struct {logic [7:0] d; logic [15:0] dv; logic pe; logic po; logic ts; int len; logic par;} tx_vec_t;
  tx_vec_t vec[6];
  initial begin
    int lm, o0, gb;
    logic pm, pe, po, ts, fl, sl;
    logic [7:0] d;
    logic [15:0] dv;
    vec[0] = '{8'h55, 16'd4, 1'b0, 1'b0, 1'b0, 640, 1'b0};
    vec[1] = '{8'h07, 16'd4, 1'b1, 1'b0, 1'b0, 704, 1'b1};
    vec[2] = '{8'h07, 16'd4, 1'b1, 1'b1, 1'b0, 704, 1'b0};
    vec[3] = '{8'h07, 16'd4, 1'b1, 1'b0, 1'b1, 768, 1'b1};
    vec[4] = '{8'hA3, 16'd0, 1'b0, 1'b0, 1'b0, 160, 1'b0};
    vec[5] = '{8'hFF, 16'd1, 1'b1, 1'b1, 1'b1, 192, 1'b1};
    rst = 1'b1; wvalid = 1'b0; wdata = '0; div = 16'd4; par_en = 1'b0; par_odd = 1'b0;
    two_stop = 1'b0; rready = 1'b1; loop = 1'b1; drv = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset wready", 32'(wready), 32'd1);
    chk("reset rvalid", 32'(rvalid), 32'd0);
    chk("reset rdata", 32'(rdata), 32'd0);
    chk("reset ferr", 32'(frame_err), 32'd0);
    chk("reset perr", 32'(par_err), 32'd0);
    chk("reset overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      send_tx($sformatf("vec%0d", i), vec[i].d, vec[i].dv, vec[i].pe, vec[i].po, vec[i].ts, lm, pm);
      chk($sformatf("vec%0d len", i), 32'(lm), 32'(vec[i].len));
      if (vec[i].pe) chk($sformatf("vec%0d parity", i), 32'(pm), 32'(vec[i].par));
      expect_rx($sformatf("vec%0d loop", i), vec[i].d, 1'b0, 1'b0);
    end
    foreach (vec[i]) if (0) $display("%0d", i);
    send_tx("even 00", 8'h00, 16'd4, 1'b1, 1'b0, 1'b0, lm, pm);
    expect_rx("even 00", 8'h00, 1'b0, 1'b0);
    send_tx("even FF", 8'hFF, 16'd4, 1'b1, 1'b0, 1'b0, lm, pm);
    expect_rx("even FF", 8'hFF, 1'b0, 1'b0);
    send_tx("even A5", 8'hA5, 16'd4, 1'b1, 1'b0, 1'b0, lm, pm);
    expect_rx("even A5", 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom); dv = 16'($urandom_range(0, 3));
      pe = 1'($urandom); po = 1'($urandom); ts = 1'($urandom);
      send_tx($sformatf("rnd loop%0d", i), d, dv, pe, po, ts, lm, pm);
      chk($sformatf("rnd loop%0d len", i), 32'(lm), 32'(16 * (dv == 0 ? 1 : int'(dv)) * (10 + int'(pe) + int'(ts))));
      expect_rx($sformatf("rnd loop%0d", i), d, 1'b0, 1'b0);
    end
    loop = 1'b0;
    drive_rx(8'h5A, 16'd4, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    expect_rx("stop low", 8'h5A, 1'b1, 1'b0);
    drive_rx(8'hC3, 16'd4, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    expect_rx("par flip", 8'hC3, 1'b0, 1'b1);
    drv = 1'b0;
    repeat (5 * 4) @(negedge clk);
    drv = 1'b1;
    repeat (128) @(negedge clk);
    chk("glitch no frame", 32'(rxq.size()), 32'(rd_idx));
    drive_rx(8'h96, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    expect_rx("after glitch", 8'h96, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom); dv = 16'($urandom_range(0, 3));
      pe = 1'($urandom); po = 1'($urandom); fl = 1'($urandom);
      sl = $urandom_range(0, 3) == 0;
      gb = $urandom_range(1, 8);
      drive_rx(d, dv, pe, po, fl, sl, gb);
      expect_rx($sformatf("rnd rx%0d", i), d, sl, pe & fl);
    end
    drv = 1'b1;
    loop = 1'b1;
    rready = 1'b0;
    o0 = ovr_cnt;
    send_tx("ovr 11", 8'h11, 16'd4, 1'b0, 1'b0, 1'b0, lm, pm);
    chk("ovr first none", 32'(ovr_cnt - o0), 32'd0);
    send_tx("ovr 22", 8'h22, 16'd4, 1'b0, 1'b0, 1'b0, lm, pm);
    chk("ovr pulse cycles", 32'(ovr_cnt - o0), 32'd1);
    chk("ovr rvalid", 32'(rvalid), 32'd1);
    chk("ovr rdata kept", 32'(rdata), 32'h11);
    div = 16'd4; par_en = 1'b0; two_stop = 1'b0; wdata = 8'hC3; wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0;
    repeat (4 * 64) @(negedge clk);
    chk("mid frame tx busy", 32'(wready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort tx", 32'(tx), 32'd1);
    chk("abort wready", 32'(wready), 32'd1);
    chk("abort rvalid", 32'(rvalid), 32'd0);
    chk("abort rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    rready = 1'b1;
    @(negedge clk);
    send_tx("post reset", 8'h3C, 16'd4, 1'b0, 1'b0, 1'b0, lm, pm);
    chk("post reset len", 32'(lm), 32'd640);
    expect_rx("post reset", 8'h3C, 1'b0, 1'b0);
    chk("no extra frames", 32'(rxq.size()), 32'(rd_idx));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
